pll_lock_monitor: RTL and testbench
===================================

PLL_LOCK_MONITOR -- requirements
Module: pll_lock_monitor

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  SETTLE_CYCLES  1024   consecutive synchronized-lock cycles required before release
  LOCK_TIMEOUT   65536  cycles allowed in WAIT_LOCK before the PLL is reset
  RST_PULSE      16     pll_rst pulse width in cycles
  CNT_W          8      loss_count width
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk         in   1      free-running reference clock (PLL input clock, not PLL output)
  rst         in   1      synchronous, active-high reset
  locked      in   1      PLL LOCK, asynchronous to clk
  fault_clr   in   1      single-cycle clear of fault and loss_count
  pll_rst     out  1      PLL reset request, active high
  sys_rst     out  1      downstream reset, active high
  ready       out  1      PLL locked and settled
  fault       out  1      sticky lock-loss flag
  loss_count  out  CNT_W  lock-loss events, saturating
REQ-003 The block SHALL use one clock, clk; rst SHALL be synchronous and active-high.

Function
REQ-004 locked SHALL pass through a 2-flop synchronizer; lock_s lags locked by exactly 2 clk edges.
REQ-005 FSM states SHALL be WAIT_LOCK, SETTLE, RUN, PLL_RESET, with a single shared timer of width clog2(max(SETTLE_CYCLES, LOCK_TIMEOUT, RST_PULSE)).
REQ-006 WAIT_LOCK transitions:
  - lock_s=1 -> SETTLE, timer cleared.
  - Else, timer = LOCK_TIMEOUT-1 -> PLL_RESET, timer cleared.
  - Else timer increments.
REQ-007 SETTLE transitions:
  - lock_s=0 -> WAIT_LOCK, timer cleared; not a loss event.
  - timer = SETTLE_CYCLES-1 with lock_s=1 -> RUN.
REQ-008 RUN: lock_s=0 SHALL cause transition to WAIT_LOCK and a loss event.
REQ-009 PLL_RESET: pll_rst=1 for exactly RST_PULSE cycles, then WAIT_LOCK with timer cleared; lock_s is ignored here.
REQ-010 All outputs SHALL be registered:
  - sys_rst = 0 and ready = 1 only while in RUN; both change on the same edge the state register does.
  - pll_rst = 1 only in PLL_RESET.
REQ-011 Release latency SHALL be 2 + SETTLE_CYCLES + 1 cycles from locked rising (locked held high) to sys_rst falling.
REQ-012 Loss latency SHALL be 2 + 1 cycles from locked falling in RUN to sys_rst rising.
REQ-013 Loss event effects:
  - fault is set.
  - loss_count increments, saturating at 2^CNT_W-1.
REQ-014 fault_clr SHALL clear fault and loss_count on the next edge; a simultaneous loss event SHALL win (fault=1, loss_count=1).
REQ-015 A lock glitch shorter than SETTLE_CYCLES during SETTLE SHALL never release sys_rst.

Reset
REQ-016 On rst the following SHALL hold on the next edge:
  - state=WAIT_LOCK, timer=0, synchronizer flops=0.
  - sys_rst=1, ready=0, pll_rst=0, fault=0, loss_count=0.
REQ-017 rst asserted mid-operation (any state, including PLL_RESET mid-pulse) SHALL abort immediately with the REQ-016 values; rst has priority over fault_clr and loss events.

Configuration
REQ-018 Macro PLL_MON_LOSS_COUNT_EN with defined: the loss_count counter SHALL be implemented per REQ-013/014.
REQ-019 Macro PLL_MON_LOSS_COUNT_EN undefined: loss_count SHALL be driven constant 0, no counter flops, fault unaffected.

Structure
REQ-020 Shared package pll_mon_pkg SHALL hold the FSM state encoding (2 bits: WAIT_LOCK=0, SETTLE=1, RUN=2, PLL_RESET=3) and default parameter constants.
REQ-021 The synchronizer SHALL be a sub-module named bit_sync (2 flops, reset to 0), reusable elsewhere.

Verification (SETTLE_CYCLES=16, LOCK_TIMEOUT=64, RST_PULSE=4, CNT_W=4)
REQ-022 Normal lock: locked=1 at cycle 10 after rst release -> sys_rst=0 and ready=1 first seen at cycle 29; pll_rst never asserted.
REQ-023 Timeout: locked held 0 -> pll_rst high cycles 64..67, then WAIT_LOCK; repeats every 68 cycles; sys_rst stays 1.
REQ-024 Glitch in SETTLE: locked=1 for 10 cycles, 0 for 1 cycle, then 1 -> no release until 16 cycles of continuous lock_s; fault=0, loss_count=0.
REQ-025 Loss in RUN: drop locked -> sys_rst=1 3 cycles later, fault=1, loss_count=1; 20 losses -> loss_count saturates at 15.
REQ-026 Clear race: fault_clr on the same cycle as a loss event -> fault=1, loss_count=1; fault_clr alone -> both 0 next cycle.
REQ-027 Reset mid-pulse: rst during pll_rst pulse cycle 2 -> pll_rst=0 next edge, all outputs at reset values; with PLL_MON_LOSS_COUNT_EN undefined, loss_count=0 throughout.

Source files
------------

// File: rtl/pll_mon_pkg.sv
// Shared definitions for the PLL lock monitor: FSM state encoding, default
// parameters and the shared-timer width helper.
package pll_mon_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2,
        PLL_RESET = 2'd3
    } state_t;

    localparam int DEF_SETTLE_CYCLES = 1024;
    localparam int DEF_LOCK_TIMEOUT  = 65536;
    localparam int DEF_RST_PULSE     = 16;
    localparam int DEF_CNT_W         = 8;

    // One timer serves every state, so it is sized for the longest interval.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous level input, reset to 0.
module bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state uses non-blocking assignments so both flops
    // sample the pre-edge values and form a true two-stage chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_monitor.sv
// Supervises a PLL LOCK signal: settles, releases sys_rst, re-resets the PLL on
// timeout, and records lock-loss events. Counter enabled by PLL_MON_LOSS_COUNT_EN.
module pll_lock_monitor
    import pll_mon_pkg::*;
#(
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int RST_PULSE     = DEF_RST_PULSE,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             locked,
    input  logic             fault_clr,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic             fault,
    output logic [CNT_W-1:0] loss_count
);

    localparam int TIMER_W = timer_width(SETTLE_CYCLES, LOCK_TIMEOUT, RST_PULSE);

    localparam logic [TIMER_W-1:0] SETTLE_LAST  = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] PULSE_LAST   = TIMER_W'(RST_PULSE - 1);

    logic               lock_s;
    logic               loss_event;
    state_t             state;
    logic [TIMER_W-1:0] timer;

    bit_sync u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (locked),
        .q   (lock_s)
    );

    assign loss_event = (state == RUN) && !lock_s;

    // Outputs are assigned alongside the state so they move on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= WAIT_LOCK;
            timer   <= '0;
            pll_rst <= 1'b0;
            sys_rst <= 1'b1;
            ready   <= 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= SETTLE;
                        timer <= '0;
                    end else if (timer == TIMEOUT_LAST) begin
                        state   <= PLL_RESET;
                        timer   <= '0;
                        pll_rst <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                SETTLE: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        timer <= '0;
                    end else if (timer == SETTLE_LAST) begin
                        state   <= RUN;
                        timer   <= '0;
                        sys_rst <= 1'b0;
                        ready   <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state   <= WAIT_LOCK;
                        timer   <= '0;
                        sys_rst <= 1'b1;
                        ready   <= 1'b0;
                    end
                end
                PLL_RESET: begin
                    if (timer == PULSE_LAST) begin
                        state   <= WAIT_LOCK;
                        timer   <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state   <= WAIT_LOCK;
                    timer   <= '0;
                    pll_rst <= 1'b0;
                    sys_rst <= 1'b1;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

    // A loss on the same edge as fault_clr wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault <= 1'b0;
        end else if (loss_event) begin
            fault <= 1'b1;
        end else if (fault_clr) begin
            fault <= 1'b0;
        end
    end

`ifdef PLL_MON_LOSS_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            loss_count <= '0;
        end else if (loss_event) begin
            if (fault_clr) begin
                loss_count <= CNT_W'(1);
            end else if (loss_count != '1) begin
                loss_count <= loss_count + 1'b1;
            end
        end else if (fault_clr) begin
            loss_count <= '0;
        end
    end
`else
    assign loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed self-checking bench for pll_lock_monitor with short timing
// parameters; loss_count expectations follow PLL_MON_LOSS_COUNT_EN.
module tb_pll_lock_monitor;

    localparam int SETTLE_CYCLES = 16;
    localparam int LOCK_TIMEOUT  = 64;
    localparam int RST_PULSE     = 4;
    localparam int CNT_W         = 4;

`ifdef PLL_MON_LOSS_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             locked;
    logic             fault_clr;
    logic             pll_rst;
    logic             sys_rst;
    logic             ready;
    logic             fault;
    logic [CNT_W-1:0] loss_count;

    int vectors     = 0;
    int miscompares = 0;
    int exp_cnt     = 0;

    pll_lock_monitor #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .RST_PULSE     (RST_PULSE),
        .CNT_W         (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .locked     (locked),
        .fault_clr  (fault_clr),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .fault      (fault),
        .loss_count (loss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle past it before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance n edges while the design must stay in reset-hold with no PLL reset.
    task automatic tick_held(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            chk({tag, "_sys_rst"}, 32'(sys_rst), 32'd1);
            chk({tag, "_pll_rst"}, 32'(pll_rst), 32'd0);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        fault_clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 64 && ready !== 1'b1; i++) tick();
        chk(tag, 32'(ready), 32'd1);
    endtask

    function automatic int sat_inc(input int v);
        return (v >= (1 << CNT_W) - 1) ? v : v + 1;
    endfunction

    initial begin
        // Reset values
        locked = 1'b0;
        do_reset();
        chk("rst_sys_rst",    32'(sys_rst),    32'd1);
        chk("rst_ready",      32'(ready),      32'd0);
        chk("rst_pll_rst",    32'(pll_rst),    32'd0);
        chk("rst_fault",      32'(fault),      32'd0);
        chk("rst_loss_count", 32'(loss_count), 32'd0);

        // Normal lock: locked rises after edge 10, release seen at edge 29
        tick_held(10, "pre_lock");
        locked = 1'b1;
        tick_held(18, "settling");
        tick();
        chk("release_sys_rst", 32'(sys_rst), 32'd0);
        chk("release_ready",   32'(ready),   32'd1);
        chk("release_pll_rst", 32'(pll_rst), 32'd0);

        // Loss in RUN: sys_rst rises on the 3rd edge after locked falls
        tick();
        tick();
        locked = 1'b0;
        tick();
        tick();
        chk("loss_edge2_sys_rst", 32'(sys_rst), 32'd0);
        tick();
        exp_cnt = CNT_EN ? 1 : 0;
        chk("loss_sys_rst",    32'(sys_rst),    32'd1);
        chk("loss_ready",      32'(ready),      32'd0);
        chk("loss_fault",      32'(fault),      32'd1);
        chk("loss_count_1",    32'(loss_count), 32'(exp_cnt));

        // Clear race: fault_clr on the loss edge -> fault=1, count restarts at 1
        locked = 1'b1;
        wait_ready("race_relock");
        locked = 1'b0;
        tick();
        tick();
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("race_sys_rst",    32'(sys_rst),    32'd1);
        chk("race_fault",      32'(fault),      32'd1);
        chk("race_loss_count", 32'(loss_count), 32'(exp_cnt));

        // fault_clr alone clears both on the next edge
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        exp_cnt = 0;
        chk("clr_fault",      32'(fault),      32'd0);
        chk("clr_loss_count", 32'(loss_count), 32'd0);

        // 20 losses: counter saturates at 2^CNT_W-1
        for (int n = 0; n < 20; n++) begin
            locked = 1'b1;
            wait_ready("sat_relock");
            locked = 1'b0;
            tick();
            tick();
            tick();
            if (CNT_EN) exp_cnt = sat_inc(exp_cnt);
            chk("sat_loss_count", 32'(loss_count), 32'(exp_cnt));
        end
        chk("sat_final_count", 32'(loss_count), CNT_EN ? 32'd15 : 32'd0);
        chk("sat_fault",       32'(fault),      32'd1);

        // Glitch in SETTLE: one-cycle drop restarts settling; release at edge 40
        do_reset();
        chk("glitch_rst_fault", 32'(fault), 32'd0);
        tick_held(10, "glitch_pre");
        locked = 1'b1;
        tick_held(10, "glitch_hi");
        locked = 1'b0;
        tick_held(1, "glitch_lo");
        locked = 1'b1;
        tick_held(18, "glitch_resettle");
        tick();
        chk("glitch_release_sys_rst", 32'(sys_rst),    32'd0);
        chk("glitch_release_ready",   32'(ready),      32'd1);
        chk("glitch_fault",           32'(fault),      32'd0);
        chk("glitch_loss_count",      32'(loss_count), 32'd0);

        // Timeout: pll_rst high on edges 64..67 and 132..135
        locked = 1'b0;
        do_reset();
        for (int e = 1; e <= 140; e++) begin
            tick();
            chk("timeout_pll_rst", 32'(pll_rst),
                ((e >= 64 && e <= 67) || (e >= 132 && e <= 135)) ? 32'd1 : 32'd0);
            chk("timeout_sys_rst", 32'(sys_rst), 32'd1);
        end

        // Reset during the second cycle of the PLL reset pulse
        do_reset();
        for (int e = 1; e <= 65; e++) tick();
        chk("midpulse_pll_rst_before", 32'(pll_rst), 32'd1);
        rst = 1'b1;
        tick();
        chk("midpulse_pll_rst",    32'(pll_rst),    32'd0);
        chk("midpulse_sys_rst",    32'(sys_rst),    32'd1);
        chk("midpulse_ready",      32'(ready),      32'd0);
        chk("midpulse_fault",      32'(fault),      32'd0);
        chk("midpulse_loss_count", 32'(loss_count), 32'd0);
        rst = 1'b0;
        for (int e = 1; e <= 63; e++) tick();
        chk("post_rst_edge63_pll_rst", 32'(pll_rst), 32'd0);
        tick();
        chk("post_rst_edge64_pll_rst", 32'(pll_rst), 32'd1);
        chk("post_rst_loss_count",     32'(loss_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
